// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 write-back / PC-update slice.
//   - icode values, register IDs (%rsp, RNONE), status codes, FSM state enum.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 4'd4;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15x64 architectural register file.
//   clk, rst        : clock, synchronous active-high reset (clears all regs)
//   src_a, src_b    : read selects; RNONE reads as zero
//   val_a, val_b    : combinational read data
//   we_e/dst_e/val_e: E write port
//   we_m/dst_m/val_m: M write port, wins over E on the same register
// Build option REG_BYPASS_EN: read ports forward same-cycle write data
// (M before E); without it they return pre-edge contents.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (we_e) regs_q[dst_e] <= val_e;
      // Second assignment wins: popq %rsp keeps the loaded value.
      if (we_m) regs_q[dst_m] <= val_m;
    end
  end

  logic [63:0] raw_a, raw_b;
  assign raw_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign raw_b = (src_b == RNONE) ? '0 : regs_q[src_b];

`ifdef REG_BYPASS_EN
  always_comb begin
    val_a = raw_a;
    if (we_e && dst_e == src_a) val_a = val_e;
    if (we_m && dst_m == src_a) val_a = val_m;
    val_b = raw_b;
    if (we_e && dst_e == src_b) val_b = val_e;
    if (we_m && dst_m == src_b) val_b = val_m;
  end
`else
  assign val_a = raw_a;
  assign val_b = raw_b;
`endif

endmodule

// File: rtl/wb_pc_stage.sv
// wb_pc_stage: Y86-64 write-back and PC-update stage.
//   Inputs : clk, rst (sync, active-high), step (commit this cycle), icode,
//            rA, rB, cnd, valC, valP, valE, valM, imem_error, dmem_error,
//            instr_invalid
//   Outputs: valA/valB (decode read ports), pc, stat, halted
// Build option REG_BYPASS_EN (see y86_regfile) forwards write data to reads.
//
// state  | meaning
// S_RUN  | accepting steps; AOK steps write regs and update pc
// S_HALT | non-AOK status latched; everything frozen until rst
module wb_pc_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        instr_invalid,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic        halted
);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [2:0]  stat_q;
  logic        halted_q;

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] new_pc;
  logic [2:0]  status_d;
  logic        commit;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    new_pc = valP;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
      IRET, IPOPQ:                    src_a = RRSP;
      default:                        src_a = RNONE;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
      default:                        src_b = RNONE;
    endcase
    case (icode)
      IRRMOVQ:                        dst_e = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:                  dst_e = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RRSP;
      default:                        dst_e = RNONE;
    endcase
    case (icode)
      IMRMOVQ, IPOPQ:                 dst_m = rA;
      default:                        dst_m = RNONE;
    endcase
    case (icode)
      ICALL:   new_pc = valC;
      IJXX:    new_pc = cnd ? valC : valP;
      IRET:    new_pc = valM;
      default: new_pc = valP;
    endcase
  end

  always_comb begin
    if (imem_error || dmem_error) status_d = STAT_ADR;
    else if (instr_invalid)       status_d = STAT_INS;
    else if (icode == IHALT)      status_d = STAT_HLT;
    else                          status_d = STAT_AOK;
  end

  // A faulting or halting step commits nothing architectural.
  assign commit = step && (state_q == S_RUN) && (status_d == STAT_AOK);

  y86_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (src_a),
    .src_b (src_b),
    .val_a (valA),
    .val_b (valB),
    .we_e  (commit && dst_e != RNONE),
    .dst_e (dst_e),
    .val_e (valE),
    .we_m  (commit && dst_m != RNONE),
    .dst_m (dst_m),
    .val_m (valM)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
    end else if (step && state_q == S_RUN) begin
      if (status_d != STAT_AOK) begin
        state_q  <= S_HALT;
        stat_q   <= status_d;
        halted_q <= 1'b1;
      end else begin
        pc_q <= new_pc;
      end
    end
  end

  assign pc     = pc_q;
  assign stat   = stat_q;
  assign halted = halted_q;

endmodule
